// File: rtl/piso_4b_tx.sv
// Parallel-in serial-out transmitter: a handshaked NBITS-bit word is shifted out LSB first on B.
// The last-bit cycle can accept the next word, so back-to-back words stream without gaps.
module piso_4b_tx #(
  parameter int NBITS = 4
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] D,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             B,
  output logic             busy,
  output logic             done
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [NBITS-1:0] sreg_reg, sreg_next;
  logic             b_reg, b_next;
  logic             last_bit;
  logic             handshake;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      sreg_reg  <= '0;
      b_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sreg_reg  <= sreg_next;
      b_reg     <= b_next;
    end
  end

  // Outputs are decoded only from registered state, never from D or load_valid.
  assign last_bit   = (state_reg == SHIFT) && (cnt_reg == LAST);
  assign load_ready = (state_reg == IDLE) || last_bit;
  assign handshake  = load_valid && load_ready;
  assign busy       = (state_reg == SHIFT);
  assign done       = last_bit;
  assign B          = b_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sreg_next  = sreg_reg;
    b_next     = b_reg;
    if (handshake) begin
      // Bit 0 goes straight to the output register; the rest wait in the shifter.
      state_next = SHIFT;
      cnt_next   = '0;
      sreg_next  = D >> 1;
      b_next     = D[0];
    end else begin
      case (state_reg)
        SHIFT: begin
          if (cnt_reg < LAST) begin
            cnt_next  = cnt_reg + CW'(1);
            b_next    = sreg_reg[0];
            sreg_next = sreg_reg >> 1;
          end else begin
            // Also catches an out-of-range counter and returns it to IDLE.
            state_next = IDLE;
            cnt_next   = '0;
            sreg_next  = '0;
            b_next     = 1'b0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          sreg_next  = '0;
          b_next     = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_4b_tx.sv
// Self-checking bench for piso_4b_tx: directed scenarios plus random traffic against a
// bit-queue reference model, with a serial-in shift register checking the received word.
module tb_piso_4b_tx;

  localparam int NBITS = 4;

  logic             sclk = 1'b0;
  logic             rst_n;
  logic [NBITS-1:0] D;
  logic             load_valid;
  logic             load_ready;
  logic             B;
  logic             busy;
  logic             done;

  always #5 sclk = ~sclk;

  piso_4b_tx #(.NBITS(NBITS)) dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .D          (D),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .B          (B),
    .busy       (busy),
    .done       (done)
  );

  // Downstream receiver: LSB arrives first, so shift in from the top.
  logic [NBITS-1:0] sipo;
  always_ff @(posedge sclk) sipo <= {B, sipo[NBITS-1:1]};

  // Reference model: the bits still to appear on B, oldest first.
  bit               exp_q[$];
  logic [NBITS-1:0] cur_word;
  logic [15:0]      blog;
  int               n_checks = 0;
  int               n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".B"},          32'(B),          32'((n > 0) ? exp_q[0] : 1'b0));
    check({tag, ".busy"},       32'(busy),       32'(n > 0));
    check({tag, ".done"},       32'(done),       32'(n == 1));
    check({tag, ".load_ready"}, 32'(load_ready), 32'(n <= 1));
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input string tag, input bit v, input logic [NBITS-1:0] d);
    bit               hs;
    bit               was_done;
    logic [NBITS-1:0] prev_word;
    check_outputs(tag);
    blog       = {blog[14:0], B};
    load_valid = v;
    D          = d;
    hs         = v && (exp_q.size() <= 1);
    was_done   = (exp_q.size() == 1);
    @(posedge sclk);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    prev_word = cur_word;
    if (hs) begin
      for (int i = 0; i < NBITS; i++) exp_q.push_back(d[i]);
      cur_word = d;
    end
    @(negedge sclk);
    if (was_done) check({tag, ".sipo"}, 32'(sipo), 32'(prev_word));
  endtask

  // Reset asserted between edges, held across one edge, released at a falling edge.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 check_outputs({tag, "_async"});
    @(posedge sclk);
    #1 check_outputs({tag, "_hold"});
    @(negedge sclk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    D          = '0;
    load_valid = 1'b0;
    cur_word   = '0;
    blog       = '0;
    #2 check_outputs("por");
    @(negedge sclk);
    rst_n = 1'b1;

    // Single word
    cycle("single_hs", 1'b1, 4'b1011);
    blog = '0;
    for (int i = 0; i < 4; i++) cycle("single", 1'b0, 4'b0000);
    check("single_stream", 32'(blog[3:0]), 32'h0000_000d);
    cycle("single_idle", 1'b0, 4'b0000);

    // Back-to-back with load_valid held
    cycle("b2b_hs", 1'b1, 4'b1011);
    blog = '0;
    for (int i = 0; i < 4; i++) cycle("b2b_hold", 1'b1, 4'b0110);
    for (int i = 0; i < 4; i++) cycle("b2b_tail", 1'b0, 4'b0000);
    check("b2b_stream", 32'(blog[7:0]), 32'h0000_00d6);
    cycle("b2b_idle", 1'b0, 4'b0000);

    // Offer during bit 2 is ignored until the last-bit cycle
    cycle("mid_hs", 1'b1, 4'b1011);
    blog = '0;
    cycle("mid_b0", 1'b0, 4'b0000);
    cycle("mid_b1", 1'b0, 4'b0000);
    check("mid_ready_b2", 32'(load_ready), 32'(0));
    cycle("mid_b2", 1'b1, 4'b0000);
    cycle("mid_b3", 1'b1, 4'b0000);
    check("mid_stream", 32'(blog[3:0]), 32'h0000_000d);
    for (int i = 0; i < 5; i++) cycle("mid_tail", 1'b0, 4'b0000);

    // Reset during bit 2, then a fresh word
    cycle("rst_hs", 1'b1, 4'b1011);
    cycle("rst_b0", 1'b0, 4'b0000);
    cycle("rst_b1", 1'b0, 4'b0000);
    do_reset("rst_mid");
    cycle("post_hs", 1'b1, 4'b0110);
    blog = '0;
    for (int i = 0; i < 4; i++) cycle("post", 1'b0, 4'b0000);
    check("post_stream", 32'(blog[3:0]), 32'h0000_0006);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset("rnd_rst");
      else cycle("rnd", ($urandom_range(0, 9) < 6), 4'($urandom));
    end
    for (int i = 0; i < 6; i++) cycle("drain", 1'b0, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
